xz_input_cond: RTL

- Upstream conditioning stage for the two-input x/z state machine.
- Takes raw asynchronous x/z levels (switches, external pins) and synchronises each one.
- Debounces each channel and drives clean, glitch-free x and z levels into the FSM, plus a change strobe.
- Guarantees the downstream FSM never sees a metastable or bouncing input.

---
 rtl/xz_cond_pkg.sv | 33 +++
 rtl/xz_debounce_ch.sv | 96 +++++++++
 rtl/xz_input_cond.sv | 115 +++++++++++
 3 files changed

// File: rtl/xz_cond_pkg.sv
// -----------------------------------------------------------------------------
// xz_cond_pkg
// Shared types and constants for the x/z input conditioning stage.
//   ch_state_t      : per-channel debounce FSM state
//   SYNC_STAGES_DEF : default synchroniser depth
//   DB_CYCLES_DEF   : default debounce qualification length
//   GLITCH_MAX      : saturation value of the rejected-glitch counter
//   glitch_sat_add  : saturating add used by the optional glitch counter
// -----------------------------------------------------------------------------
package xz_cond_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } ch_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 16;

    localparam logic [7:0] GLITCH_MAX = 8'hFF;

    // Adds 0..2 to the counter and clamps at GLITCH_MAX instead of wrapping.
    function automatic logic [7:0] glitch_sat_add(input logic [7:0] cnt,
                                                  input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        if (sum > {1'b0, GLITCH_MAX}) begin
            return GLITCH_MAX;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/xz_debounce_ch.sv
// -----------------------------------------------------------------------------
// xz_debounce_ch
// One conditioning channel: synchroniser, debounce FSM and counter, clean
// output flop, plus single-cycle status pulses for the top level.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   raw           in   unsynchronised input level
//   clean         out  debounced level (direct flop output)
//   upd           out  high in the cycle before the edge on which clean changes
//   glitch        out  high in the cycle before the edge on which a pending
//                      change is abandoned (CHECK -> STABLE without update)
//   check_nxt     out  FSM will be in ST_CHECK after the next edge
// -----------------------------------------------------------------------------
module xz_debounce_ch
    import xz_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic upd,
    output logic glitch,
    output logic check_nxt
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    ch_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   s;

    // Oldest synchroniser stage is the only one the FSM may look at.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s != clean_q) begin
                    // A one-cycle qualification window means the first
                    // differing sample is already sufficient.
                    if (DB_CYCLES == 1) begin
                        clean_d = s;
                    end else begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_CHECK: begin
                if (s == clean_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    clean_d = s;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean     = clean_q;
    assign upd       = (clean_d != clean_q);
    assign glitch    = (state_q == ST_CHECK) && (s == clean_q);
    assign check_nxt = (state_d == ST_CHECK);

endmodule

// File: rtl/xz_input_cond.sv
// -----------------------------------------------------------------------------
// xz_input_cond
// Conditions the raw x/z levels for the downstream x/z state machine: each
// input is synchronised and debounced independently, and the clean levels are
// presented together with a change strobe and a busy flag.
// Optional build macro: XZ_COND_GLITCH_CNT_EN adds a saturating 8-bit count of
// rejected glitches on output glitch_cnt.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   x_raw       in   unsynchronised x
//   z_raw       in   unsynchronised z
//   x           out  clean debounced x
//   z           out  clean debounced z
//   xz_chg      out  one-cycle pulse after x and/or z changed
//   busy        out  either channel is qualifying a pending change
//   glitch_cnt  out  rejected-glitch count (XZ_COND_GLITCH_CNT_EN only)
// -----------------------------------------------------------------------------
module xz_input_cond
    import xz_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x_raw,
    input  logic       z_raw,
    output logic       x,
    output logic       z,
    output logic       xz_chg,
`ifdef XZ_COND_GLITCH_CNT_EN
    output logic       busy,
    output logic [7:0] glitch_cnt
`else
    output logic       busy
`endif
);

    logic upd_x, upd_z;
    logic glitch_x, glitch_z;
    logic chk_x, chk_z;
    logic xz_chg_q, xz_chg_d;
    logic busy_q, busy_d;

    xz_debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_ch_x (
        .clk       (clk),
        .rst       (rst),
        .raw       (x_raw),
        .clean     (x),
        .upd       (upd_x),
        .glitch    (glitch_x),
        .check_nxt (chk_x)
    );

    xz_debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_ch_z (
        .clk       (clk),
        .rst       (rst),
        .raw       (z_raw),
        .clean     (z),
        .upd       (upd_z),
        .glitch    (glitch_z),
        .check_nxt (chk_z)
    );

    // Both strobes are registered from the channels' next-state view so they
    // line up with the clean outputs and the FSM states they describe.
    always_comb begin
        xz_chg_d = upd_x | upd_z;
        busy_d   = chk_x | chk_z;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xz_chg_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            xz_chg_q <= xz_chg_d;
            busy_q   <= busy_d;
        end
    end

    assign xz_chg = xz_chg_q;
    assign busy   = busy_q;

`ifdef XZ_COND_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    // Simultaneous aborts on both channels count twice.
    always_comb begin
        glitch_cnt_d = glitch_sat_add(glitch_cnt_q,
                                      {glitch_x & glitch_z, glitch_x ^ glitch_z});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = glitch_x ^ glitch_z;
`endif

endmodule
